// File: rtl/instr_encoder.sv
// Packs MIPS instruction descriptors into 32-bit words and writes them to instruction memory.
// Optional INSTR_ENCODER_PARITY_EN adds imem_wpar, the registered even parity of imem_wdata.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              full,
    output logic              err,
    output logic              done,
    output logic [ADDR_W:0]   prog_len
`ifdef INSTR_ENCODER_PARITY_EN
    ,
    output logic              imem_wpar
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);

    state_t            state, state_d;
    logic              in_ready_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic [ADDR_W:0]   count, count_d;
    logic              full_d;
    logic              err_d;
    logic              done_d;
    logic [ADDR_W:0]   prog_len_d;
    logic              last_q, last_d;
    logic              kind_ok;
    logic [31:0]       enc_word;

    assign kind_ok = (in_kind <= 3'd4);

    always_comb begin
        enc_word = 32'h0;
        case (in_kind)
            3'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            3'd1:    enc_word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
            3'd2:    enc_word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
            3'd3:    enc_word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
            3'd4:    enc_word = {6'b000010, in_imm};
            default: enc_word = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state;
        in_ready_d = in_ready;
        we_d       = imem_we;
        addr_d     = imem_addr;
        wdata_d    = imem_wdata;
        count_d    = count;
        full_d     = full;
        err_d      = err;
        done_d     = 1'b0;
        prog_len_d = prog_len;
        last_d     = last_q;
        case (state)
            S_IDLE: begin
                in_ready_d = !full;
                if (in_valid && in_ready) begin
                    if (kind_ok) begin
                        wdata_d    = enc_word;
                        we_d       = 1'b1;
                        last_d     = in_last;
                        state_d    = S_WRITE;
                        in_ready_d = 1'b0;
                    end else begin
                        // Invalid kinds are dropped but may still terminate the program.
                        err_d = 1'b1;
                        if (in_last) begin
                            state_d    = S_DONE;
                            done_d     = 1'b1;
                            prog_len_d = count;
                            in_ready_d = 1'b0;
                        end
                    end
                end
            end
            S_WRITE: begin
                in_ready_d = 1'b0;
                if (imem_ready) begin
                    we_d    = 1'b0;
                    count_d = count + ONE_C;
                    addr_d  = imem_addr + ADDR_W'(1);
                    if (last_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        prog_len_d = count + ONE_C;
                    end else if (count + ONE_C == DEPTH_C) begin
                        full_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_IDLE;
                        in_ready_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                count_d    = '0;
                addr_d     = BASE;
                full_d     = 1'b0;
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= 32'h0;
            count      <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
            done       <= 1'b0;
            prog_len   <= '0;
            last_q     <= 1'b0;
        end else begin
            state      <= state_d;
            in_ready   <= in_ready_d;
            imem_we    <= we_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            count      <= count_d;
            full       <= full_d;
            err        <= err_d;
            done       <= done_d;
            prog_len   <= prog_len_d;
            last_q     <= last_d;
        end
    end

`ifdef INSTR_ENCODER_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imem_wpar <= 1'b0;
        end else begin
            imem_wpar <= ^wdata_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder, built with DEPTH=4 to reach the full condition.
module tb_instr_encoder;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_kind = '0;
    logic [4:0]        in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]        in_funct = '0;
    logic [25:0]       in_imm = '0;
    logic              in_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready = 1'b1;
    logic              full;
    logic              err;
    logic              done;
    logic [ADDR_W:0]   prog_len;

    int n_cmp = 0;
    int n_fail = 0;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(4), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ready(imem_ready), .full(full), .err(err), .done(done),
        .prog_len(prog_len)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Waits (bounded) for in_ready, presents one descriptor for a single accept edge.
    task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [25:0] imm, input logic last);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready_timeout: in_ready=%b required 1", in_ready);
        end
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_last = last; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({in_ready, imem_we, full, err, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: rdy/we/full/err/done=%b required 00000",
                     {in_ready, imem_we, full, err, done});
        end
        n_cmp++;
        if (imem_addr !== 8'd0 || imem_wdata !== 32'h0 || prog_len !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_values: addr=%0d wdata=%h prog_len=%0d required 0 0 0",
                     imem_addr, imem_wdata, prog_len);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_rtype();
        do_reset();
        send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 26'd0, 1'b0);
        n_cmp++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h00221820) begin
            n_fail++;
            $display("FAIL rtype_write: we=%b addr=%0d wdata=%h required 1 0 00221820",
                     imem_we, imem_addr, imem_wdata);
        end
        tick();
        n_cmp++;
        if (imem_we !== 1'b0 || imem_addr !== 8'd1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rtype_after: we=%b addr=%0d rdy=%b required 0 1 1",
                     imem_we, imem_addr, in_ready);
        end
    endtask

    task automatic test_program();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h8D280004;
        exp_w[1] = 32'hAC020008;
        exp_w[2] = 32'h1022FFFF;
        exp_w[3] = 32'h08000010;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: send(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 26'd4, 1'b0);
                1: send(3'd2, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 26'd8, 1'b0);
                2: send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 26'h0FFFF, 1'b0);
                default: send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'h10, 1'b1);
            endcase
            n_cmp++;
            if (imem_we !== 1'b1 || imem_addr !== 8'(i) || imem_wdata !== exp_w[i]) begin
                n_fail++;
                $display("FAIL prog_word%0d: we=%b addr=%0d wdata=%h required 1 %0d %h",
                         i, imem_we, imem_addr, imem_wdata, i, exp_w[i]);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || prog_len !== 9'd4) begin
            n_fail++;
            $display("FAIL prog_done: done=%b prog_len=%0d required 1 4", done, prog_len);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || imem_addr !== 8'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL prog_after_done: done=%b addr=%0d rdy=%b required 0 0 1",
                     done, imem_addr, in_ready);
        end
        send(3'd0, 5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 26'd0, 1'b0);
        n_cmp++;
        if (imem_addr !== 8'd0 || imem_wdata !== 32'h00853080) begin
            n_fail++;
            $display("FAIL prog_restart: addr=%0d wdata=%h required 0 00853080",
                     imem_addr, imem_wdata);
        end
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        imem_ready = 1'b0;
        send(3'd1, 5'd3, 5'd7, 5'd0, 5'd0, 6'd0, 26'h1234, 1'b0);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h8C671234 ||
                in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: we=%b addr=%0d wdata=%h rdy=%b required 1 0 8c671234 0",
                         c, imem_we, imem_addr, imem_wdata, in_ready);
            end
            tick();
        end
        imem_ready = 1'b1;
        tick();
        n_cmp++;
        if (imem_we !== 1'b0 || imem_addr !== 8'd1) begin
            n_fail++;
            $display("FAIL stall_release: we=%b addr=%0d required 0 1", imem_we, imem_addr);
        end
        send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'h3, 1'b1);
        tick();
        n_cmp++;
        if (done !== 1'b1 || prog_len !== 9'd2) begin
            n_fail++;
            $display("FAIL stall_count: done=%b prog_len=%0d required 1 2", done, prog_len);
        end
        tick();
    endtask

    task automatic test_invalid_kind();
        do_reset();
        send(3'd6, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 26'd1, 1'b0);
        n_cmp++;
        if (err !== 1'b1 || imem_we !== 1'b0 || imem_addr !== 8'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_kind: err=%b we=%b addr=%0d rdy=%b required 1 0 0 1",
                     err, imem_we, imem_addr, in_ready);
        end
        send(3'd2, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 26'd8, 1'b0);
        n_cmp++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'hAC020008 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_next: we=%b addr=%0d wdata=%h err=%b required 1 0 ac020008 1",
                     imem_we, imem_addr, imem_wdata, err);
        end
        tick();
        send(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'd0, 1'b1);
        n_cmp++;
        if (done !== 1'b1 || prog_len !== 9'd1 || imem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_last: done=%b prog_len=%0d we=%b required 1 1 0",
                     done, prog_len, imem_we);
        end
        tick();
        n_cmp++;
        if (err !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b done=%b required 1 0", err, done);
        end
    endtask

    task automatic test_zero_length();
        do_reset();
        send(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'd0, 1'b1);
        n_cmp++;
        if (done !== 1'b1 || prog_len !== 9'd0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_length: done=%b prog_len=%0d err=%b required 1 0 1",
                     done, prog_len, err);
        end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(3'd0, 5'(i), 5'd0, 5'd0, 5'd0, 6'h20, 26'd0, 1'b0);
            tick();
        end
        n_cmp++;
        if (full !== 1'b1 || in_ready !== 1'b0 || imem_addr !== 8'd4) begin
            n_fail++;
            $display("FAIL full_set: full=%b rdy=%b addr=%0d required 1 0 4",
                     full, in_ready, imem_addr);
        end
        in_valid = 1'b1;
        in_kind = 3'd0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (full !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL full_hold%0d: full=%b rdy=%b we=%b required 1 0 0",
                         c, full, in_ready, imem_we);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 26'd0, 1'b0);
        tick();
        imem_ready = 1'b0;
        send(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 26'd4, 1'b0);
        n_cmp++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd1) begin
            n_fail++;
            $display("FAIL midwrite_pre: we=%b addr=%0d required 1 1", imem_we, imem_addr);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (imem_we !== 1'b0 || imem_addr !== 8'd0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midwrite_reset: we=%b addr=%0d rdy=%b required 0 0 0",
                     imem_we, imem_addr, in_ready);
        end
        rst_n = 1'b1;
        imem_ready = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1 || imem_we !== 1'b0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL midwrite_recover: rdy=%b we=%b full=%b required 1 0 0",
                     in_ready, imem_we, full);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_program();
        test_stall();
        test_invalid_kind();
        test_zero_length();
        test_full();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
